// File: rtl/pwm_counter_pkg.sv
// Shared types for the PWM carrier counter: controller states and carrier shapes.
package pwm_counter_pkg;

   typedef enum logic [1:0] {
      STOPPED  = 2'd0,
      RUNNING  = 2'd1,
      DRAINING = 2'd2
   } counterState_e;

   typedef enum logic {
      MODE_SAWTOOTH = 1'b0,
      MODE_TRIANGLE = 1'b1
   } counterMode_e;

endpackage

// File: rtl/pwm_shadow_regs.sv
// Staging/active configuration pair: staging is written by load, active is
// refreshed from staging by reload. The *_c outputs show what active will hold
// after the current edge, so a load coinciding with a reload is picked up.
module pwm_shadow_regs
   import pwm_counter_pkg::*;
#(
   parameter int unsigned COUNTER_WIDTH = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     load,
   input  logic                     reload,
   input  logic [COUNTER_WIDTH-1:0] periodIn,
   input  logic [COUNTER_WIDTH-1:0] cmpLowIn,
   input  logic [COUNTER_WIDTH-1:0] cmpHighIn,
   input  logic                     modeIn,
   output logic [COUNTER_WIDTH-1:0] activePeriod,
   output logic                     activeMode,
   output logic [COUNTER_WIDTH-1:0] nextPeriod_c,
   output logic [COUNTER_WIDTH-1:0] nextCmpLow_c,
   output logic [COUNTER_WIDTH-1:0] nextCmpHigh_c,
   output logic                     nextMode_c
);

   logic [COUNTER_WIDTH-1:0] stagingPeriod, stagingCmpLow, stagingCmpHigh;
   counterMode_e             stagingMode;
   logic [COUNTER_WIDTH-1:0] activeCmpLow, activeCmpHigh;
   counterMode_e             activeModeReg;

   logic [COUNTER_WIDTH-1:0] stagingPeriodNext, stagingCmpLowNext, stagingCmpHighNext;
   counterMode_e             stagingModeNext;

   // Next staging and next active values.
   always_comb begin
      stagingPeriodNext  = stagingPeriod;
      stagingCmpLowNext  = stagingCmpLow;
      stagingCmpHighNext = stagingCmpHigh;
      stagingModeNext    = stagingMode;
      if (load) begin
         stagingPeriodNext  = periodIn;
         stagingCmpLowNext  = cmpLowIn;
         stagingCmpHighNext = cmpHighIn;
         stagingModeNext    = counterMode_e'(modeIn);
      end
      nextPeriod_c  = activePeriod;
      nextCmpLow_c  = activeCmpLow;
      nextCmpHigh_c = activeCmpHigh;
      nextMode_c    = activeModeReg;
      if (reload) begin
         nextPeriod_c  = stagingPeriodNext;
         nextCmpLow_c  = stagingCmpLowNext;
         nextCmpHigh_c = stagingCmpHighNext;
         nextMode_c    = stagingModeNext;
      end
   end

   // Staging and active register update.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stagingPeriod  <= '0;
         stagingCmpLow  <= '0;
         stagingCmpHigh <= '0;
         stagingMode    <= MODE_SAWTOOTH;
         activePeriod   <= '0;
         activeCmpLow   <= '0;
         activeCmpHigh  <= '0;
         activeModeReg  <= MODE_SAWTOOTH;
      end else begin
         stagingPeriod  <= stagingPeriodNext;
         stagingCmpLow  <= stagingCmpLowNext;
         stagingCmpHigh <= stagingCmpHighNext;
         stagingMode    <= stagingModeNext;
         activePeriod   <= nextPeriod_c;
         activeCmpLow   <= nextCmpLow_c;
         activeCmpHigh  <= nextCmpHigh_c;
         activeModeReg  <= counterMode_e'(nextMode_c);
      end
   end

   assign activeMode = activeModeReg;

endmodule

// File: rtl/pwm_carrier_counter.sv
// PWM carrier counter: sawtooth or triangle count with shadowed period and
// compare values, run/drain/stop control and synchronous restart.
module pwm_carrier_counter
   import pwm_counter_pkg::*;
#(
   parameter int unsigned COUNTER_WIDTH = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     run,
   input  logic                     counter_mode,
   input  logic [COUNTER_WIDTH-1:0] period,
   input  logic [COUNTER_WIDTH-1:0] cmp_low,
   input  logic [COUNTER_WIDTH-1:0] cmp_high,
   input  logic                     cfg_valid,
   input  logic                     sync_in,
   output logic [COUNTER_WIDTH-1:0] count,
   output logic                     match_low,
   output logic                     match_high,
   output logic                     counter_stopped,
   output logic                     period_end
);

   counterState_e            state, stateNext;
   logic                     dirDown, dirDownNext;
   logic [COUNTER_WIDTH-1:0] countNext;
   logic                     matchLowNext, matchHighNext, periodEndNext;
   logic                     reload;

   logic [COUNTER_WIDTH-1:0] activePeriod;
   logic                     activeMode;
   logic [COUNTER_WIDTH-1:0] nextPeriod, nextCmpLow, nextCmpHigh;
   logic                     nextMode;

   pwm_shadow_regs #(
      .COUNTER_WIDTH (COUNTER_WIDTH)
   ) shadowRegs (
      .clock         (clock),
      .reset         (reset),
      .load          (cfg_valid),
      .reload        (reload),
      .periodIn      (period),
      .cmpLowIn      (cmp_low),
      .cmpHighIn     (cmp_high),
      .modeIn        (counter_mode),
      .activePeriod  (activePeriod),
      .activeMode    (activeMode),
      .nextPeriod_c  (nextPeriod),
      .nextCmpLow_c  (nextCmpLow),
      .nextCmpHigh_c (nextCmpHigh),
      .nextMode_c    (nextMode)
   );

   // Next state, next count/direction and the flags describing the next count.
   always_comb begin
      stateNext     = state;
      reload        = period_end;
      countNext     = '0;
      dirDownNext   = 1'b0;
      matchLowNext  = 1'b0;
      matchHighNext = 1'b0;
      periodEndNext = 1'b0;

      case (state)
         STOPPED: begin
            if (run) begin
               stateNext = RUNNING;
               reload    = 1'b1;
            end
         end
         RUNNING: begin
            if (!run) stateNext = DRAINING;
         end
         DRAINING: begin
            if (run)             stateNext = RUNNING;
            else if (period_end) stateNext = STOPPED;
         end
         default: stateNext = STOPPED;
      endcase

      if (stateNext != STOPPED) begin
         if (state == STOPPED || sync_in || nextPeriod == '0) begin
            countNext = '0;
         end else if (period_end) begin
            // A triangle period ends on a shared zero, so the next period resumes at 1.
            countNext = (counterMode_e'(activeMode) == MODE_TRIANGLE) ? COUNTER_WIDTH'(1) : '0;
         end else if (!dirDown) begin
            if (count >= activePeriod) begin
               if (counterMode_e'(activeMode) == MODE_TRIANGLE) begin
                  countNext   = count - COUNTER_WIDTH'(1);
                  dirDownNext = 1'b1;
               end else begin
                  countNext = '0;
               end
            end else begin
               countNext = count + COUNTER_WIDTH'(1);
            end
         end else if (count == '0) begin
            countNext = COUNTER_WIDTH'(1);
         end else begin
            countNext   = count - COUNTER_WIDTH'(1);
            dirDownNext = 1'b1;
         end

         if (nextPeriod == '0)
            periodEndNext = 1'b1;
         else if (counterMode_e'(nextMode) == MODE_TRIANGLE)
            periodEndNext = (countNext == '0) && dirDownNext;
         else
            periodEndNext = (countNext == nextPeriod);

         matchLowNext  = (countNext < nextCmpLow);
         matchHighNext = (countNext >= nextCmpHigh);
      end
   end

   // State, count and registered output flags.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state           <= STOPPED;
         count           <= '0;
         dirDown         <= 1'b0;
         match_low       <= 1'b0;
         match_high      <= 1'b0;
         period_end      <= 1'b0;
         counter_stopped <= 1'b1;
      end else begin
         state           <= stateNext;
         count           <= countNext;
         dirDown         <= dirDownNext;
         match_low       <= matchLowNext;
         match_high      <= matchHighNext;
         period_end      <= periodEndNext;
         counter_stopped <= (stateNext == STOPPED);
      end
   end

endmodule
